// File: rtl/cavlc_pkg.sv
// rtl/cavlc_pkg.sv - shared types and widths for the CAVLC coefficient statistics stage
package cavlc_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    localparam int MAX_COEFF = 16;
    localparam int TC_W      = 5;
    localparam int T1_W      = 2;
    localparam int TZ_W      = 4;

endpackage

// File: rtl/cavlc_t1_tracker.sv
// rtl/cavlc_t1_tracker.sv - trailing-ones run length and sign history for one block
module cavlc_t1_tracker
    import cavlc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            accept,
    input  logic            is_zero,
    input  logic            is_one,
    input  logic            sign,
    input  logic            clear,
    output logic [T1_W-1:0] t1_run_next,
    output logic [2:0]      sgn_next
);

    logic [T1_W-1:0] t1_run;
    logic [2:0]      sgn;

    // Next run/sign values; the top registers its results from these so the
    // final coefficient of a block is already reflected.
    always_comb begin
        t1_run_next = t1_run;
        sgn_next    = sgn;
        if (accept && !is_zero) begin
            if (is_one) begin
                t1_run_next = (t1_run == T1_W'(3)) ? T1_W'(3) : t1_run + T1_W'(1);
                sgn_next    = {sgn[1:0], sign};
            end else begin
                t1_run_next = '0;
                sgn_next    = '0;
            end
        end
    end

    // Run and sign history registers, cleared when the block is handed off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t1_run <= '0;
            sgn    <= '0;
        end else if (clear) begin
            t1_run <= '0;
            sgn    <= '0;
        end else begin
            t1_run <= t1_run_next;
            sgn    <= sgn_next;
        end
    end

endmodule

// File: rtl/cavlc_coeff_stats.sv
// rtl/cavlc_coeff_stats.sv - per-block TotalCoeff/TrailingOnes/TotalZeros from zigzag coefficients
module cavlc_coeff_stats
    import cavlc_pkg::*;
#(
    parameter int CoeffWidth = 16,
    parameter int NumCoeff   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CoeffWidth-1:0] in_coeff,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [TC_W-1:0]       total_coeff,
    output logic [T1_W-1:0]       trailing_ones,
    output logic [2:0]            t1_signs,
    output logic [TZ_W-1:0]       total_zeros
);

    localparam logic [4:0] LAST_POS = 5'(NumCoeff - 1);

    state_t          state_q;
    state_t          state_d;
    logic [4:0]      pos;
    logic [TC_W-1:0] tc;
    logic [4:0]      last_nz;

    logic            accept;
    logic            is_zero;
    logic            is_one;
    logic            final_accept;
    logic            handoff;
    logic [TC_W-1:0] tc_next;
    logic [4:0]      last_nz_next;
    logic [4:0]      tz_diff;
    logic [T1_W-1:0] t1_run_next;
    logic [2:0]      sgn_next;

    assign in_ready     = (state_q == COLLECT);
    assign accept       = in_valid && in_ready;
    // Equality tests only: +1 or all-ones (-1), no magnitude arithmetic needed.
    assign is_zero      = (in_coeff == '0);
    assign is_one       = (in_coeff == CoeffWidth'(1)) || (in_coeff == '1);
    assign final_accept = accept && (pos == LAST_POS);
    assign handoff      = out_valid && out_ready;

    assign tc_next      = (accept && !is_zero) ? tc + TC_W'(1) : tc;
    assign last_nz_next = (accept && !is_zero) ? pos + 5'd1 : last_nz;
    assign tz_diff      = last_nz_next - tc_next;

    cavlc_t1_tracker u_t1_tracker (
        .clk         (clk),
        .rst         (rst),
        .accept      (accept),
        .is_zero     (is_zero),
        .is_one      (is_one),
        .sign        (in_coeff[CoeffWidth-1]),
        .clear       (handoff),
        .t1_run_next (t1_run_next),
        .sgn_next    (sgn_next)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave COLLECT on the last coefficient, leave HOLD on handoff.
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (final_accept) state_d = HOLD;
            HOLD:    if (handoff)      state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // Block accumulators; cleared only once the consumer has taken the results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos     <= '0;
            tc      <= '0;
            last_nz <= '0;
        end else if (handoff) begin
            pos     <= '0;
            tc      <= '0;
            last_nz <= '0;
        end else if (accept) begin
            pos     <= pos + 5'd1;
            tc      <= tc_next;
            last_nz <= last_nz_next;
        end
    end

    // Result registers, loaded with the values that include the final coefficient.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid     <= 1'b0;
            total_coeff   <= '0;
            trailing_ones <= '0;
            t1_signs      <= '0;
            total_zeros   <= '0;
        end else if (final_accept) begin
            out_valid     <= 1'b1;
            total_coeff   <= tc_next;
            trailing_ones <= t1_run_next;
            t1_signs      <= sgn_next;
            total_zeros   <= (tc_next == '0) ? '0 : tz_diff[TZ_W-1:0];
        end else if (handoff) begin
            out_valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cavlc_coeff_stats.sv
// tb/tb_cavlc_coeff_stats.sv - self-checking bench for cavlc_coeff_stats
module tb_cavlc_coeff_stats;

    typedef logic signed [15:0] blk_t [16];

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        iv16, ir16, ov16, or16;
    logic [15:0] ic16;
    logic [4:0]  tc16;
    logic [1:0]  t116;
    logic [2:0]  s16;
    logic [3:0]  tz16;

    logic        iv4, ir4, ov4, or4;
    logic [15:0] ic4;
    logic [4:0]  tc4;
    logic [1:0]  t14;
    logic [2:0]  s4;
    logic [3:0]  tz4;

    int checks = 0;
    int errors = 0;

    cavlc_coeff_stats #(.CoeffWidth(16), .NumCoeff(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_coeff(ic16),
        .out_valid(ov16), .out_ready(or16), .total_coeff(tc16), .trailing_ones(t116),
        .t1_signs(s16), .total_zeros(tz16)
    );

    cavlc_coeff_stats #(.CoeffWidth(16), .NumCoeff(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_coeff(ic4),
        .out_valid(ov4), .out_ready(or4), .total_coeff(tc4), .trailing_ones(t14),
        .t1_signs(s4), .total_zeros(tz4)
    );

    // Reference: counts taken over the whole block, trailing ones scanned from the end.
    function automatic void model(input blk_t c, input int n,
                                  output int etc, output int et1, output int es, output int etz);
        int  last;
        bit  done;
        etc = 0; last = -1; et1 = 0; es = 0; etz = 0; done = 0;
        for (int i = 0; i < n; i++) if (c[i] != 0) begin etc++; last = i; end
        for (int i = 0; i <= last; i++) if (c[i] == 0) etz++;
        for (int i = n - 1; i >= 0; i--) begin
            if (!done && c[i] != 0) begin
                if ((c[i] == 1 || c[i] == -1) && et1 < 3) begin
                    if (c[i] < 0) es = es | (1 << et1);
                    et1++;
                end else begin
                    done = 1;
                end
            end
        end
    endfunction

    function automatic logic signed [15:0] rand_coeff();
        int r;
        r = $urandom_range(99);
        if (r < 40) return 16'sd0;
        if (r < 55) return 16'sd1;
        if (r < 70) return -16'sd1;
        if (r < 75) return 16'sh7fff;
        if (r < 80) return 16'sh8000;
        if (r < 85) return 16'sd2;
        if (r < 90) return -16'sd2;
        return 16'($urandom);
    endfunction

    function automatic logic cur_ready(input bit which);
        return which ? ir4 : ir16;
    endfunction

    task automatic drive(input bit which, input logic v, input logic [15:0] c);
        if (which) begin iv4 = v; ic4 = c; end
        else begin iv16 = v; ic16 = c; end
    endtask

    task automatic send_block(input bit which, input blk_t c, input int n,
                              input int gap_pct, output bit timeout);
        int w;
        int g;
        timeout = 0;
        for (int i = 0; i < n; i++) begin
            g = 0;
            while ($urandom_range(99) < gap_pct && g < 4) begin
                drive(which, 1'b0, 16'($urandom));
                @(posedge clk); #1;
                g++;
            end
            w = 0;
            while (!cur_ready(which) && w < 50) begin
                @(posedge clk); #1;
                w++;
            end
            if (w == 50) timeout = 1;
            drive(which, 1'b1, c[i]);
            @(posedge clk); #1;
            drive(which, 1'b0, 16'($urandom));
        end
    endtask

    task automatic test_reset();
        checks++;
        if (ir16 !== 1'b1 || ov16 !== 1'b0 || ir4 !== 1'b1 || ov4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b (n4: %b %b), required 1 0", ir16, ov16, ir4, ov4);
        end
        checks++;
        if (tc16 !== 5'd0 || t116 !== 2'd0 || s16 !== 3'd0 || tz16 !== 4'd0) begin
            errors++;
            $display("FAIL reset_results: tc=%0d t1=%0d s=%b tz=%0d, required all 0", tc16, t116, s16, tz16);
        end
    endtask

    task automatic test_directed(input string name, input blk_t b,
                                 input int etc, input int et1, input int es, input int etz);
        bit to;
        or16 = 1'b1;
        send_block(0, b, 16, 0, to);
        checks++;
        if (to || ov16 !== 1'b1 || tc16 !== 5'(etc) || t116 !== 2'(et1) || s16 !== 3'(es) || tz16 !== 4'(etz)) begin
            errors++;
            $display("FAIL %s: to=%b valid=%b tc=%0d t1=%0d s=%b tz=%0d, required valid=1 tc=%0d t1=%0d s=%b tz=%0d",
                     name, to, ov16, tc16, t116, s16, tz16, etc, et1, 3'(es), etz);
        end
        @(posedge clk); #1;
        checks++;
        if (ov16 !== 1'b0 || ir16 !== 1'b1) begin
            errors++;
            $display("FAIL %s_one_cycle: out_valid=%b in_ready=%b, required 0 1", name, ov16, ir16);
        end
        or16 = 1'b0;
    endtask

    task automatic test_standard();
        blk_t b;
        b = '{16'sd0, 16'sd3, 16'sd0, 16'sd1, -16'sd1, -16'sd1, 16'sd0, 16'sd1,
              16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
        test_directed("standard", b, 5, 3, 3'b110, 3);
    endtask

    task automatic test_all_zero();
        blk_t b;
        for (int i = 0; i < 16; i++) b[i] = 16'sd0;
        test_directed("all_zero", b, 0, 0, 0, 0);
    endtask

    task automatic test_all_twos();
        blk_t b;
        for (int i = 0; i < 16; i++) b[i] = 16'sd2;
        test_directed("all_twos", b, 16, 0, 0, 0);
    endtask

    task automatic test_large_resets_run();
        blk_t b;
        for (int i = 0; i < 16; i++) b[i] = 16'sd0;
        b[0] = 16'sd1; b[1] = -16'sd1; b[2] = 16'sd5; b[4] = -16'sd1;
        test_directed("large_reset", b, 4, 1, 3'b001, 1);
    endtask

    task automatic test_random();
        blk_t b;
        bit   to;
        int   etc, et1, es, etz, hold;
        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < 16; i++) b[i] = rand_coeff();
            model(b, 16, etc, et1, es, etz);
            or16 = 1'b0;
            send_block(0, b, 16, 25, to);
            hold = $urandom_range(3);
            for (int h = 0; h < hold; h++) begin @(posedge clk); #1; end
            checks++;
            if (to || ov16 !== 1'b1 || tc16 !== 5'(etc) || t116 !== 2'(et1) || s16 !== 3'(es) || tz16 !== 4'(etz)) begin
                errors++;
                $display("FAIL random_%0d: to=%b valid=%b tc=%0d t1=%0d s=%b tz=%0d, required tc=%0d t1=%0d s=%b tz=%0d",
                         k, to, ov16, tc16, t116, s16, tz16, etc, et1, 3'(es), etz);
            end
            or16 = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (ov16 !== 1'b0) begin
                errors++;
                $display("FAIL random_%0d_release: out_valid=%b, required 0", k, ov16);
            end
            or16 = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        blk_t b;
        bit   to;
        int   etc, et1, es, etz;
        for (int i = 0; i < 16; i++) b[i] = rand_coeff();
        b[15] = -16'sd1;
        model(b, 16, etc, et1, es, etz);
        or16 = 1'b0;
        send_block(0, b, 16, 30, to);
        for (int h = 0; h < 10; h++) begin
            checks++;
            if (to || ov16 !== 1'b1 || ir16 !== 1'b0 || tc16 !== 5'(etc) || t116 !== 2'(et1)
                || s16 !== 3'(es) || tz16 !== 4'(etz)) begin
                errors++;
                $display("FAIL hold_%0d: valid=%b ready=%b tc=%0d t1=%0d s=%b tz=%0d, required 1 0 %0d %0d %b %0d",
                         h, ov16, ir16, tc16, t116, s16, tz16, etc, et1, 3'(es), etz);
            end
            drive(0, 1'b1, 16'($urandom));
            @(posedge clk); #1;
        end
        drive(0, 1'b0, 16'h0);
        or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;
        checks++;
        if (ov16 !== 1'b0 || ir16 !== 1'b1) begin
            errors++;
            $display("FAIL release: out_valid=%b in_ready=%b, required 0 1", ov16, ir16);
        end
        for (int i = 0; i < 16; i++) b[i] = rand_coeff();
        model(b, 16, etc, et1, es, etz);
        send_block(0, b, 16, 0, to);
        checks++;
        if (to || ov16 !== 1'b1 || tc16 !== 5'(etc) || t116 !== 2'(et1) || s16 !== 3'(es) || tz16 !== 4'(etz)) begin
            errors++;
            $display("FAIL after_release: valid=%b tc=%0d t1=%0d s=%b tz=%0d, required tc=%0d t1=%0d s=%b tz=%0d",
                     ov16, tc16, t116, s16, tz16, etc, et1, 3'(es), etz);
        end
        or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;
    endtask

    task automatic test_rst_mid_block();
        blk_t b;
        bit   to;
        int   etc, et1, es, etz;
        for (int i = 0; i < 16; i++) b[i] = (i % 2 == 0) ? -16'sd1 : 16'sd7;
        send_block(0, b, 7, 0, to);
        rst = 1'b1;
        #1;
        checks++;
        if (ov16 !== 1'b0 || ir16 !== 1'b1 || tc16 !== 5'd0) begin
            errors++;
            $display("FAIL rst_mid: out_valid=%b in_ready=%b tc=%0d, required 0 1 0", ov16, ir16, tc16);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) b[i] = rand_coeff();
        model(b, 16, etc, et1, es, etz);
        or16 = 1'b1;
        send_block(0, b, 16, 10, to);
        checks++;
        if (to || ov16 !== 1'b1 || tc16 !== 5'(etc) || t116 !== 2'(et1) || s16 !== 3'(es) || tz16 !== 4'(etz)) begin
            errors++;
            $display("FAIL after_rst: valid=%b tc=%0d t1=%0d s=%b tz=%0d, required tc=%0d t1=%0d s=%b tz=%0d",
                     ov16, tc16, t116, s16, tz16, etc, et1, 3'(es), etz);
        end
        @(posedge clk); #1;
        or16 = 1'b0;
    endtask

    task automatic test_num_coeff_4();
        blk_t b;
        bit   to;
        int   etc, et1, es, etz;
        for (int i = 0; i < 16; i++) b[i] = 16'sd0;
        b[0] = -16'sd1;
        or4 = 1'b1;
        send_block(1, b, 4, 0, to);
        checks++;
        if (to || ov4 !== 1'b1 || tc4 !== 5'd1 || t14 !== 2'd1 || s4 !== 3'b001 || tz4 !== 4'd0) begin
            errors++;
            $display("FAIL nc4_dc: valid=%b tc=%0d t1=%0d s=%b tz=%0d, required 1 1 1 001 0", ov4, tc4, t14, s4, tz4);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 16; i++) b[i] = (i < 4) ? rand_coeff() : 16'sd0;
            model(b, 4, etc, et1, es, etz);
            send_block(1, b, 4, 20, to);
            checks++;
            if (to || ov4 !== 1'b1 || tc4 !== 5'(etc) || t14 !== 2'(et1) || s4 !== 3'(es) || tz4 !== 4'(etz)) begin
                errors++;
                $display("FAIL nc4_random_%0d: valid=%b tc=%0d t1=%0d s=%b tz=%0d, required tc=%0d t1=%0d s=%b tz=%0d",
                         k, ov4, tc4, t14, s4, tz4, etc, et1, 3'(es), etz);
            end
            @(posedge clk); #1;
        end
        or4 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        iv16 = 1'b0; ic16 = '0; or16 = 1'b0;
        iv4 = 1'b0; ic4 = '0; or4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_standard();
        test_all_zero();
        test_all_twos();
        test_large_resets_run();
        test_random();
        test_backpressure();
        test_rst_mid_block();
        test_num_coeff_4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cavlc_coeff_stats.md
# cavlc_coeff_stats

Streaming statistics stage placed directly downstream of the zigzag scan in the CAVLC encoder. It accepts one zigzag-ordered coefficient per cycle for each 4x4 block. After the last coefficient of a block, it presents the block's TotalCoeff, TrailingOnes, trailing-one signs and TotalZeros for the coeff_token and total_zeros encoders. A valid/ready handshake on both sides provides backpressure.

## Interface
Parameters:
- CoeffWidth, 16 — signed two's-complement coefficient width.
- NumCoeff, 16 — coefficients per block; legal values 4 (chroma DC), 15 (AC), 16.

Ports:
- clk  in  1  — single clock, rising edge.
- rst  in  1  — asynchronous, active-high reset.
- in_valid  in  1  — in_coeff is valid.
- in_ready  out  1  — block can accept a coefficient.
- in_coeff  in  CoeffWidth  — next coefficient in zigzag order.
- out_valid  out  1  — block results are valid.
- out_ready  in  1  — consumer accepts the results.
- total_coeff  out  5  — count of nonzero coefficients, 0..NumCoeff.
- trailing_ones  out  2  — trailing ±1 count, 0..3.
- t1_signs  out  3  — trailing-one signs, 1 = negative:
  - bit0 is the highest-frequency trailing one.
  - Bits at or above trailing_ones are 0.
- total_zeros  out  4  — zeros before the last nonzero coefficient.

## Operation
- Two states: COLLECT and HOLD.
- Reset state:
  - State is COLLECT.
  - in_ready=1, out_valid=0.
  - All result outputs, accumulators and the 5-bit position counter pos are 0.
- COLLECT:
  - in_ready=1.
  - A coefficient is accepted when in_valid & in_ready. Each accept increments pos.
  - On an accept of a nonzero coefficient:
    - tc increments.
    - last_nz is set to pos+1.
  - On an accept of ±1 (coefficient equal to 1 or to all-ones): t1_run saturates at 3; sgn <= {sgn[1:0], coeff_msb}.
  - On an accept of a coefficient with magnitude >1: t1_run <= 0, sgn <= 0.
  - Zero coefficients change only pos.
- COLLECT to HOLD, on the accept where pos == NumCoeff-1:
  - Results are registered from the values updated by this final coefficient:
    - total_coeff = tc.
    - trailing_ones = t1_run.
    - t1_signs = sgn.
    - total_zeros = last_nz - tc, or 0 when tc==0.
  - out_valid <= 1, and state moves to HOLD.
- HOLD:
  - in_ready=0.
  - Outputs are stable until out_valid & out_ready.
- HOLD to COLLECT, on out_valid & out_ready:
  - out_valid <= 0.
  - pos, tc, t1_run, sgn and last_nz are cleared.
  - Result outputs keep their last values; they are don't-care while out_valid=0.
- Arithmetic: the magnitude test uses only equality comparisons, with no abs() and no overflow risk. total_zeros fits in 4 bits because last_nz is at most 16 and tc is at least 1 when it is used.

## Timing
- in_ready is combinational from state only, never from out_ready.
- Latency: out_valid rises on the clock edge that accepts the final coefficient, and is visible the following cycle.
- Throughput is one block per NumCoeff+1 cycles when out_ready is held at 1. This includes one HOLD cycle with no overlap.
- in_valid gaps stall accumulation without side effects.
- in_coeff is ignored in HOLD and whenever in_valid=0.
- rst assertion at any point, including mid-block or in HOLD, returns to the reset state immediately. The partial block is discarded.
- out_ready asserted while out_valid=0 has no effect.

## Structure
- Shared package cavlc_pkg holds:
  - The state enum {COLLECT, HOLD}.
  - MAX_COEFF = 16.
  - Result field widths TC_W = 5, T1_W = 2, TZ_W = 4.
- One sub-module, cavlc_t1_tracker, holds t1_run and sgn. Its inputs are accept, is_zero, is_one and sign; a clear input is asserted on block completion. It isolates the trailing-ones rules for unit test.
- The top level holds the FSM, pos, tc, last_nz and the output registers.

## Test plan
- Standard example 0,3,0,1,-1,-1,0,1,0,0,0,0,0,0,0,0 with out_ready=1 → total_coeff=5, trailing_ones=3, t1_signs=3'b110, total_zeros=3, out_valid for exactly 1 cycle.
- All sixteen coefficients zero → total_coeff=0, trailing_ones=0, t1_signs=0, total_zeros=0.
- Sixteen coefficients equal to 2 → total_coeff=16, trailing_ones=0, total_zeros=0.
- Sequence 1,-1,5,0,-1,0,… → total_coeff=4, trailing_ones=1, t1_signs=3'b001, total_zeros=1.
  - Checks that a large level resets the run.
- Backpressure and stalls:
  - Stimulus: out_ready=0 for 10 cycles after out_valid; random in_valid gaps.
  - Response: outputs are stable and in_ready=0 throughout the hold.
  - On release, the next block is accepted starting the next cycle, and its results are correct.
- rst pulse after the 7th coefficient → out_valid=0 and in_ready=1. A following full block yields results independent of the aborted data.
- NumCoeff=4 with coefficients -1,0,0,0 → total_coeff=1, trailing_ones=1, t1_signs=3'b001, total_zeros=0.
